bullet_alloc: RTL and testbench

Bullet pool allocator and fire arbiter for the two-player tank game. It takes fire requests from P1 and P2, shares the single bullet slot pool between them with round-robin fairness, and enforces per-player cooldown and live-bullet limits. It picks a free slot and computes a spawn position in front of the firing tank, so a new bullet never overlaps its own tank. It sits between the player input logic and the bullet pool, whose active/owner vectors also feed the collision checker.

---
 rtl/bullet_alloc.sv | 245 ++++++++++++++++++++++++
 tb/tb_bullet_alloc.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bullet_alloc.sv
// ---------------------------------------------------------------------------
// bullet_alloc
//
// Bullet pool allocator and fire arbiter for the two-player tank game.
// Takes fire requests from both players, shares the bullet slot pool between
// them with round-robin fairness, enforces per-player cooldown and live-bullet
// limits, picks the lowest free slot and computes a spawn position that sits
// directly in front of the firing tank without overlapping it.
//
// Ports
//   clk, rstn                  clock, synchronous active-low reset
//   frame_tick                 one-cycle pulse per video frame (cooldown rate)
//   p1_/p2_fire                fire request level
//   p1_/p2_x, _y               tank top-left, tank is 3 wide x 4 high
//   p1_/p2_dir                 facing: 0 up, 1 down, 2 left, 3 right
//   p1_/p2_alive               tank alive
//   bullet_active/owner        pool occupancy and per-slot owner (1 = P2)
//   spawn_*                    registered one-cycle spawn command to the pool
//   p1_/p2_live                registered live-bullet count per player
//   p1_/p2_cd_busy             cooldown counter nonzero
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | evaluate eligibility, arbitrate, register the spawn command
// ISSUE  | spawn_valid high for exactly this cycle
// SETTLE | pool latches the slot, live counts catch up before next decision
// ---------------------------------------------------------------------------
module bullet_alloc #(
  parameter int BULLET_NUM     = 64,
  parameter int SLOT_W         = 7,
  parameter int COOLDOWN       = 30,
  parameter int MAX_PER_PLAYER = 8,
  parameter int ARENA_W        = 160,
  parameter int ARENA_H        = 120
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  frame_tick,
  input  logic                  p1_fire,
  input  logic                  p2_fire,
  input  logic [7:0]            p1_x,
  input  logic [7:0]            p1_y,
  input  logic [7:0]            p2_x,
  input  logic [7:0]            p2_y,
  input  logic [1:0]            p1_dir,
  input  logic [1:0]            p2_dir,
  input  logic                  p1_alive,
  input  logic                  p2_alive,
  input  logic [BULLET_NUM-1:0] bullet_active,
  input  logic [BULLET_NUM-1:0] bullet_owner,
  output logic                  spawn_valid,
  output logic [SLOT_W-1:0]     spawn_slot,
  output logic                  spawn_owner,
  output logic [7:0]            spawn_x,
  output logic [7:0]            spawn_y,
  output logic [1:0]            spawn_dir,
  output logic [7:0]            p1_live,
  output logic [7:0]            p2_live,
  output logic                  p1_cd_busy,
  output logic                  p2_cd_busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_SETTLE = 2'd2
  } state_t;

  typedef struct packed {
    logic       ok;
    logic [7:0] x;
    logic [7:0] y;
  } spawn_pos_t;

  localparam logic [8:0] ARENA_W9 = 9'(ARENA_W);
  localparam logic [8:0] ARENA_H9 = 9'(ARENA_H);
  localparam logic [8:0] MAX_P9   = 9'(MAX_PER_PLAYER);
  localparam logic [7:0] CD_LOAD  = 8'(COOLDOWN);

  // Spawn position and bounds check. Everything is done at 9 bits so that
  // x+3 / y+4 near the top of the 8-bit range cannot wrap back into bounds.
  function automatic spawn_pos_t calc_pos(input logic [7:0] x,
                                          input logic [7:0] y,
                                          input logic [1:0] dir);
    logic [8:0] sx;
    logic [8:0] sy;
    logic       ok;
    sx = {1'b0, x};
    sy = {1'b0, y};
    ok = 1'b1;
    case (dir)
      2'd0: begin
        ok = (y >= 8'd2);
        sy = {1'b0, y} - 9'd2;
      end
      2'd1: begin
        sy = {1'b0, y} + 9'd4;
      end
      2'd2: begin
        ok = (x >= 8'd2);
        sx = {1'b0, x} - 9'd2;
        sy = {1'b0, y} + 9'd1;
      end
      default: begin
        sx = {1'b0, x} + 9'd3;
        sy = {1'b0, y} + 9'd1;
      end
    endcase
    if (sx + 9'd2 > ARENA_W9) ok = 1'b0;
    if (sy + 9'd2 > ARENA_H9) ok = 1'b0;
    calc_pos = '{ok: ok, x: sx[7:0], y: sy[7:0]};
  endfunction

  state_t              state_q, state_d;
  logic                prio_p2_q, prio_p2_d;   // 1: P2 wins a tie next time
  logic [7:0]          cd1_q, cd1_d;
  logic [7:0]          cd2_q, cd2_d;
  logic [7:0]          live1_q, live1_d;
  logic [7:0]          live2_q, live2_d;
  logic                spawn_valid_q, spawn_valid_d;
  logic [SLOT_W-1:0]   spawn_slot_q, spawn_slot_d;
  logic                spawn_owner_q, spawn_owner_d;
  logic [7:0]          spawn_x_q, spawn_x_d;
  logic [7:0]          spawn_y_q, spawn_y_d;
  logic [1:0]          spawn_dir_q, spawn_dir_d;

  spawn_pos_t          pos1, pos2;
  logic                free_found;
  logic [SLOT_W-1:0]   free_idx;
  logic                elig1, elig2;
  logic                grant1, grant2;

  assign pos1 = calc_pos(p1_x, p1_y, p1_dir);
  assign pos2 = calc_pos(p2_x, p2_y, p2_dir);

  // Lowest free slot: scanning downward leaves the smallest index last.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = BULLET_NUM - 1; i >= 0; i--) begin
      if (!bullet_active[i]) begin
        free_found = 1'b1;
        free_idx   = SLOT_W'(i);
      end
    end
  end

  always_comb begin
    live1_d = '0;
    live2_d = '0;
    for (int i = 0; i < BULLET_NUM; i++) begin
      if (bullet_active[i] && !bullet_owner[i]) live1_d = live1_d + 8'd1;
      if (bullet_active[i] &&  bullet_owner[i]) live2_d = live2_d + 8'd1;
    end
  end

  always_comb begin
    elig1 = p1_fire && p1_alive && (cd1_q == 8'd0) &&
            ({1'b0, live1_q} < MAX_P9) && free_found && pos1.ok;
    elig2 = p2_fire && p2_alive && (cd2_q == 8'd0) &&
            ({1'b0, live2_q} < MAX_P9) && free_found && pos2.ok;
    grant1 = (state_q == S_IDLE) && elig1 && (!elig2 || !prio_p2_q);
    grant2 = (state_q == S_IDLE) && elig2 && (!elig1 ||  prio_p2_q);
  end

  always_comb begin
    state_d       = state_q;
    prio_p2_d     = prio_p2_q;
    spawn_valid_d = 1'b0;
    spawn_slot_d  = spawn_slot_q;
    spawn_owner_d = spawn_owner_q;
    spawn_x_d     = spawn_x_q;
    spawn_y_d     = spawn_y_q;
    spawn_dir_d   = spawn_dir_q;

    case (state_q)
      S_IDLE: begin
        if (grant1 || grant2) begin
          state_d       = S_ISSUE;
          spawn_valid_d = 1'b1;
          spawn_slot_d  = free_idx;
          spawn_owner_d = grant2;
          spawn_x_d     = grant2 ? pos2.x : pos1.x;
          spawn_y_d     = grant2 ? pos2.y : pos1.y;
          spawn_dir_d   = grant2 ? p2_dir : p1_dir;
          prio_p2_d     = grant1;
        end
      end
      S_ISSUE:  state_d = S_SETTLE;
      S_SETTLE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // A grant load overrides a same-cycle frame decrement.
    cd1_d = cd1_q;
    if (frame_tick && (cd1_q != 8'd0)) cd1_d = cd1_q - 8'd1;
    if (grant1) cd1_d = CD_LOAD;

    cd2_d = cd2_q;
    if (frame_tick && (cd2_q != 8'd0)) cd2_d = cd2_q - 8'd1;
    if (grant2) cd2_d = CD_LOAD;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      prio_p2_q     <= 1'b0;
      cd1_q         <= '0;
      cd2_q         <= '0;
      live1_q       <= '0;
      live2_q       <= '0;
      spawn_valid_q <= 1'b0;
      spawn_slot_q  <= '0;
      spawn_owner_q <= 1'b0;
      spawn_x_q     <= '0;
      spawn_y_q     <= '0;
      spawn_dir_q   <= '0;
    end else begin
      state_q       <= state_d;
      prio_p2_q     <= prio_p2_d;
      cd1_q         <= cd1_d;
      cd2_q         <= cd2_d;
      live1_q       <= live1_d;
      live2_q       <= live2_d;
      spawn_valid_q <= spawn_valid_d;
      spawn_slot_q  <= spawn_slot_d;
      spawn_owner_q <= spawn_owner_d;
      spawn_x_q     <= spawn_x_d;
      spawn_y_q     <= spawn_y_d;
      spawn_dir_q   <= spawn_dir_d;
    end
  end

  assign spawn_valid = spawn_valid_q;
  assign spawn_slot  = spawn_slot_q;
  assign spawn_owner = spawn_owner_q;
  assign spawn_x     = spawn_x_q;
  assign spawn_y     = spawn_y_q;
  assign spawn_dir   = spawn_dir_q;
  assign p1_live     = live1_q;
  assign p2_live     = live2_q;
  assign p1_cd_busy  = (cd1_q != 8'd0);
  assign p2_cd_busy  = (cd2_q != 8'd0);

endmodule

// File: tb/tb_bullet_alloc.sv
// Testbench for bullet_alloc: directed scenarios followed by a randomized run,
// all checked cycle by cycle against a behavioural model. The bench also plays
// the bullet pool (sets the granted slot one cycle after spawn_valid).
module tb_bullet_alloc;
  localparam int BN   = 64;
  localparam int SW   = 7;
  localparam int CD   = 30;
  localparam int MAXP = 8;
  localparam int AW   = 160;
  localparam int AH   = 120;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          frame_tick = 1'b0;
  logic          p1_fire = 1'b0, p2_fire = 1'b0;
  logic [7:0]    p1_x = 8'd10, p1_y = 8'd20, p2_x = 8'd50, p2_y = 8'd50;
  logic [1:0]    p1_dir = 2'd0, p2_dir = 2'd1;
  logic          p1_alive = 1'b1, p2_alive = 1'b1;
  logic [BN-1:0] bullet_active = '0;
  logic [BN-1:0] bullet_owner = '0;

  logic          spawn_valid;
  logic [SW-1:0] spawn_slot;
  logic          spawn_owner;
  logic [7:0]    spawn_x, spawn_y;
  logic [1:0]    spawn_dir;
  logic [7:0]    p1_live, p2_live;
  logic          p1_cd_busy, p2_cd_busy;

  always #5 clk = ~clk;

  bullet_alloc dut (
    .clk(clk), .rstn(rstn), .frame_tick(frame_tick),
    .p1_fire(p1_fire), .p2_fire(p2_fire),
    .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
    .p1_dir(p1_dir), .p2_dir(p2_dir),
    .p1_alive(p1_alive), .p2_alive(p2_alive),
    .bullet_active(bullet_active), .bullet_owner(bullet_owner),
    .spawn_valid(spawn_valid), .spawn_slot(spawn_slot), .spawn_owner(spawn_owner),
    .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_dir(spawn_dir),
    .p1_live(p1_live), .p2_live(p2_live),
    .p1_cd_busy(p1_cd_busy), .p2_cd_busy(p2_cd_busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  int m_busy;          // cycles left before the allocator may decide again
  int m_cd [2];
  int m_live [2];
  int m_next_p2;       // 1: P2 wins the next tie
  int m_sv, m_slot, m_owner, m_x, m_y, m_dir;
  int pend, pend_slot, pend_owner;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void spawn_pos(input int x, input int y, input int d,
                                    output int sx, output int sy, output bit ok);
    sx = x;
    sy = y;
    case (d)
      0: sy = y - 2;
      1: sy = y + 4;
      2: begin sx = x - 2; sy = y + 1; end
      default: begin sx = x + 3; sy = y + 1; end
    endcase
    ok = (sx >= 0) && (sy >= 0) && (sx + 2 <= AW) && (sy + 2 <= AH);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_cd[0] = 0; m_cd[1] = 0; m_live[0] = 0; m_live[1] = 0;
    m_next_p2 = 0; m_sv = 0; m_slot = 0; m_owner = 0; m_x = 0; m_y = 0; m_dir = 0;
  endtask

  // One clock: predict from the inputs present now, step the clock, compare.
  task automatic cycle();
    int  freei, grant, tick, rst;
    int  cnt [2];
    int  sx [2], sy [2], dr [2];
    bit  ok [2], el [2];
    freei = -1; grant = -1; cnt[0] = 0; cnt[1] = 0;
    tick = int'(frame_tick); rst = !rstn;
    for (int i = BN - 1; i >= 0; i--) if (!bullet_active[i]) freei = i;
    for (int i = 0; i < BN; i++) if (bullet_active[i]) cnt[bullet_owner[i]]++;
    spawn_pos(int'(p1_x), int'(p1_y), int'(p1_dir), sx[0], sy[0], ok[0]);
    spawn_pos(int'(p2_x), int'(p2_y), int'(p2_dir), sx[1], sy[1], ok[1]);
    dr[0] = int'(p1_dir); dr[1] = int'(p2_dir);
    el[0] = p1_fire && p1_alive && m_cd[0] == 0 && m_live[0] < MAXP && freei >= 0 && ok[0];
    el[1] = p2_fire && p2_alive && m_cd[1] == 0 && m_live[1] < MAXP && freei >= 0 && ok[1];
    if (m_busy == 0) begin
      if (el[0] && el[1]) grant = m_next_p2;
      else if (el[0])     grant = 0;
      else if (el[1])     grant = 1;
    end
    @(posedge clk); #1;
    if (rst) model_reset();
    else begin
      for (int p = 0; p < 2; p++) begin
        if (grant == p) m_cd[p] = CD;
        else if (tick != 0 && m_cd[p] > 0) m_cd[p]--;
      end
      m_live[0] = cnt[0]; m_live[1] = cnt[1];
      m_sv = (grant >= 0);
      if (m_busy > 0) m_busy--;
      if (grant >= 0) begin
        m_slot = freei; m_owner = grant; m_x = sx[grant]; m_y = sy[grant];
        m_dir = dr[grant]; m_next_p2 = (grant == 0); m_busy = 2;
      end
    end
    if (pend != 0) begin
      bullet_active[pend_slot] = 1'b1;
      bullet_owner[pend_slot]  = pend_owner[0];
      pend = 0;
    end
    chk("valid", 32'(spawn_valid), m_sv);
    chk("slot",  32'(spawn_slot),  m_slot);
    chk("owner", 32'(spawn_owner), m_owner);
    chk("x",     32'(spawn_x),     m_x);
    chk("y",     32'(spawn_y),     m_y);
    chk("dir",   32'(spawn_dir),   m_dir);
    chk("live1", 32'(p1_live),     m_live[0]);
    chk("live2", 32'(p2_live),     m_live[1]);
    chk("busy1", 32'(p1_cd_busy),  32'(m_cd[0] != 0));
    chk("busy2", 32'(p2_cd_busy),  32'(m_cd[1] != 0));
    if (m_sv != 0) begin
      pend = 1; pend_slot = m_slot; pend_owner = m_owner;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    p1_fire = 1'b0; p2_fire = 1'b0; frame_tick = 1'b0;
    rstn = 1'b0; cycle(); rstn = 1'b1;
  endtask

  initial begin
    int n_sp;
    int g_owner [3], g_slot [3], g_cyc [3];
    model_reset();
    pend = 0; pend_slot = 0; pend_owner = 0;

    // reset values
    rstn = 1'b0; cycle(); cycle(); rstn = 1'b1;
    chk("rst_valid", 32'(spawn_valid), 0);
    chk("rst_live1", 32'(p1_live), 0);
    chk("rst_busy1", 32'(p1_cd_busy), 0);

    // single shot P1 at (10,20) facing up
    cycle();
    p1_x = 8'd10; p1_y = 8'd20; p1_dir = 2'd0; p1_fire = 1'b1;
    cycle();
    p1_fire = 1'b0;
    chk("ss_valid", 32'(spawn_valid), 1);
    chk("ss_slot",  32'(spawn_slot), 0);
    chk("ss_xy",    {16'(spawn_x), 16'(spawn_y)}, {16'd10, 16'd18});
    cycle();
    chk("ss_one_cycle", 32'(spawn_valid), 0);
    for (int i = 0; i < 29; i++) begin frame_tick = 1'b1; cycle(); frame_tick = 1'b0; cycle(); end
    chk("ss_cd_29", 32'(p1_cd_busy), 1);
    frame_tick = 1'b1; cycle(); frame_tick = 1'b0;
    chk("ss_cd_30", 32'(p1_cd_busy), 0);

    // simultaneous fire, round robin from P1
    do_reset(); bullet_active = '0; bullet_owner = '0;
    p2_x = 8'd50; p2_y = 8'd50; p2_dir = 2'd1;
    p1_fire = 1'b1; p2_fire = 1'b1; frame_tick = 1'b1;
    n_sp = 0;
    for (int c = 0; c < 80; c++) begin
      cycle();
      if (spawn_valid && n_sp < 3) begin
        g_owner[n_sp] = int'(spawn_owner); g_slot[n_sp] = int'(spawn_slot); g_cyc[n_sp] = c;
        n_sp++;
      end
    end
    p1_fire = 1'b0; p2_fire = 1'b0; frame_tick = 1'b0;
    chk("sim_count", n_sp, 3);
    chk("sim_owners", {8'(g_owner[0]), 8'(g_owner[1]), 8'(g_owner[2])}, {8'd0, 8'd1, 8'd0});
    chk("sim_slots",  {8'(g_slot[0]),  8'(g_slot[1]),  8'(g_slot[2])},  {8'd0, 8'd1, 8'd2});
    chk("sim_gap", g_cyc[1] - g_cyc[0], 3);

    // per-player limit: P2 owns 8 live bullets
    do_reset(); bullet_active = '0; bullet_owner = '0;
    bullet_active[7:0] = 8'hFF; bullet_owner[7:0] = 8'hFF;
    run(2);
    p2_fire = 1'b1; n_sp = 0;
    for (int c = 0; c < 6; c++) begin cycle(); if (spawn_valid) n_sp++; end
    chk("lim_p2_none", n_sp, 0);
    chk("lim_p2_live", 32'(p2_live), 8);
    p1_fire = 1'b1; cycle(); p1_fire = 1'b0; p2_fire = 1'b0;
    chk("lim_p1_grant", {8'(spawn_valid), 8'(spawn_owner), 8'(spawn_slot)}, {8'd1, 8'd0, 8'd8});

    // pool full (live counts still zero from the empty cycle before)
    do_reset(); bullet_active = '0; bullet_owner = '0; run(2);
    bullet_active = '1; p1_fire = 1'b1; p2_fire = 1'b1;
    cycle();
    chk("full_none", 32'(spawn_valid), 0);
    chk("full_cd", {8'(p1_cd_busy), 8'(p2_cd_busy)}, 16'd0);
    p1_fire = 1'b0; p2_fire = 1'b0; bullet_active = '0; run(2);
    bullet_active = '1; bullet_active[37] = 1'b0; p1_fire = 1'b1;
    cycle(); p1_fire = 1'b0;
    chk("full_slot37", {8'(spawn_valid), 8'(spawn_slot)}, {8'd1, 8'd37});

    // edge suppression and the mirrored in-bounds shots
    do_reset(); bullet_active = '0; bullet_owner = '0;
    p1_x = 8'd10; p1_y = 8'd1; p1_dir = 2'd0; p1_fire = 1'b1; n_sp = 0;
    for (int c = 0; c < 4; c++) begin cycle(); if (spawn_valid) n_sp++; end
    p1_fire = 1'b0;
    chk("edge_up_none", n_sp, 0);
    chk("edge_up_cd", 32'(p1_cd_busy), 0);
    p2_x = 8'd157; p2_y = 8'd40; p2_dir = 2'd3; p2_fire = 1'b1; n_sp = 0;
    for (int c = 0; c < 4; c++) begin cycle(); if (spawn_valid) n_sp++; end
    p2_fire = 1'b0;
    chk("edge_right_none", n_sp, 0);
    chk("edge_right_cd", 32'(p2_cd_busy), 0);
    p1_dir = 2'd1; p1_fire = 1'b1; cycle(); p1_fire = 1'b0;
    chk("edge_down_xy", {16'(spawn_x), 16'(spawn_y)}, {16'd10, 16'd5});
    run(3);
    p2_dir = 2'd2; p2_fire = 1'b1; cycle(); p2_fire = 1'b0;
    chk("edge_left_xy", {8'(spawn_owner), 16'(spawn_x), 16'(spawn_y)}, {8'd1, 16'd155, 16'd41});

    // reset during ISSUE
    do_reset(); bullet_active = '0; bullet_owner = '0;
    p1_x = 8'd10; p1_y = 8'd20; p1_dir = 2'd0; p1_fire = 1'b1;
    cycle(); p1_fire = 1'b0;
    chk("rmid_issue", 32'(spawn_valid), 1);
    rstn = 1'b0; cycle(); rstn = 1'b1;
    chk("rmid_valid", 32'(spawn_valid), 0);
    chk("rmid_state", {8'(p1_live), 8'(p1_cd_busy)}, 16'd0);
    p1_fire = 1'b1; cycle(); p1_fire = 1'b0;
    chk("rmid_idle_grant", 32'(spawn_valid), 1);

    // frame_tick in the grant cycle: load wins
    do_reset();
    p1_fire = 1'b1; frame_tick = 1'b1; cycle(); p1_fire = 1'b0; frame_tick = 1'b0;
    chk("coll_grant", 32'(spawn_valid), 1);
    for (int i = 0; i < 29; i++) begin frame_tick = 1'b1; cycle(); frame_tick = 1'b0; cycle(); end
    chk("coll_cd_29", 32'(p1_cd_busy), 1);
    frame_tick = 1'b1; cycle(); frame_tick = 1'b0;
    chk("coll_cd_30", 32'(p1_cd_busy), 0);

    // randomized traffic
    do_reset(); bullet_active = '0; bullet_owner = '0;
    for (int c = 0; c < 3000; c++) begin
      p1_fire    = ($urandom_range(0, 99) < 60);
      p2_fire    = ($urandom_range(0, 99) < 60);
      p1_alive   = ($urandom_range(0, 99) < 92);
      p2_alive   = ($urandom_range(0, 99) < 92);
      frame_tick = ($urandom_range(0, 99) < 50);
      p1_dir     = 2'($urandom_range(0, 3));
      p2_dir     = 2'($urandom_range(0, 3));
      p1_x = 8'(($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 160));
      p1_y = 8'(($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 120));
      p2_x = 8'(($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 160));
      p2_y = 8'(($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 120));
      if ($urandom_range(0, 99) < 8) bullet_active[$urandom_range(0, BN - 1)] = 1'b0;
      rstn = ($urandom_range(0, 299) != 0);
      cycle();
    end
    rstn = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
